// File: rtl/ct_f_spsram_2048x144_ctrl_pkg.sv
// Shared state type and idle pin levels for the 2048x144 single-port SRAM
// request controller.
package ct_f_spsram_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Macro pins are active low, so "idle" means every strobe held high.
  localparam logic CEN_IDLE     = 1'b1;
  localparam logic GWEN_IDLE    = 1'b1;
  localparam logic WEN_IDLE_BIT = 1'b1;

endpackage

// File: rtl/ct_f_spsram_2048x144_ctrl_if.sv
// Request/response stream between a client and the SRAM controller.
interface ct_f_spsram_2048x144_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 144
);

  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );

endinterface

// File: rtl/ct_f_spsram_2048x144_ctrl_rsp_fifo.sv
// Small synchronous response FIFO; head entry is presented combinationally
// and stays stable until popped.
module ct_f_spsram_rsp_fifo #(
  parameter int DATA_WIDTH = 144,
  parameter int RSP_DEPTH  = 2,
  localparam int CW        = $clog2(RSP_DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CW-1:0]         count
);

  localparam int PW = $clog2(RSP_DEPTH);

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage is cleared on reset so an empty FIFO presents zero data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign head_data = mem[rd_ptr];

  // The upstream credit rule must keep these from ever firing.
  always @(posedge CLK) begin
    if (!RST) begin
      assert (!(push && !pop && count == CW'(RSP_DEPTH)));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: rtl/ct_f_spsram_2048x144_ctrl.sv
// Request-side controller for the 2048x144 single-port SRAM macro: zero-fill
// sweep after reset, then reads and masked writes with credit-limited responses.
module ct_f_spsram_2048x144_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 144,
  parameter int RSP_DEPTH  = 2,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  ct_f_spsram_2048x144_ctrl_if.slave bus,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_A,
  output logic                  sram_CEN,
  output logic                  sram_GWEN,
  output logic [DATA_WIDTH-1:0] sram_WEN,
  output logic [DATA_WIDTH-1:0] sram_D,
  input  logic [DATA_WIDTH-1:0] sram_Q
);

  import ct_f_spsram_ctrl_pkg::*;

  localparam int            CW        = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(RSP_DEPTH);
  localparam state_t        RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_pend;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occ;
  logic                  sweep;
  logic                  run;
  logic                  rsp_pop;
  logic                  acc;
  logic                  rd_acc;
  logic                  wr_acc;

  // Gating with RST keeps the pins idle and req_rdy low while reset is held.
  assign sweep   = (state == ST_INIT) && !RST;
  assign run     = (state == ST_RUN) && !RST;
  assign rsp_pop = bus.rsp_vld && bus.rsp_rdy;

  // Occupancy counts the read already in the macro, so credit never overruns.
  assign occ         = {1'b0, fifo_count} + (CW + 1)'(rd_pend) - (CW + 1)'(rsp_pop);
  assign bus.req_rdy = run && (bus.req_wr || occ < DEPTH_C);
  assign acc         = bus.req_vld && bus.req_rdy;
  assign rd_acc      = acc && !bus.req_wr;
  assign wr_acc      = acc && bus.req_wr && (|bus.req_wmask);
  assign bus.rsp_vld = fifo_count != '0;
  assign init_done   = (state == ST_RUN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= RST_STATE;
      init_cnt <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= rd_acc;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + ADDR_WIDTH'(1);
        if (&init_cnt) state <= ST_RUN;
      end
    end
  end

  always_comb begin
    sram_CEN  = CEN_IDLE;
    sram_GWEN = GWEN_IDLE;
    sram_WEN  = {DATA_WIDTH{WEN_IDLE_BIT}};
    sram_D    = '0;
    sram_A    = '0;
    if (sweep) begin
      sram_CEN  = 1'b0;
      sram_GWEN = 1'b0;
      sram_WEN  = '0;
      sram_A    = init_cnt;
    end else if (rd_acc) begin
      sram_CEN = 1'b0;
      sram_A   = bus.req_addr;
    end else if (wr_acc) begin
      sram_CEN  = 1'b0;
      sram_GWEN = 1'b0;
      sram_WEN  = ~bus.req_wmask;
      sram_D    = bus.req_wdata;
      sram_A    = bus.req_addr;
    end
  end

  ct_f_spsram_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (rd_pend),
    .pop      (rsp_pop),
    .push_data(sram_Q),
    .head_data(bus.rsp_rdata),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_ct_f_spsram_2048x144_ctrl.sv
// Self-checking bench: behavioural SRAM macro plus a word-level memory and
// response-order model of the controller.
module tb_ct_f_spsram_2048x144_ctrl;

  localparam int AW    = 11;
  localparam int DW    = 144;
  localparam int DEPTH = 2;
  localparam int N     = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          init_done;
  logic [AW-1:0] sram_A;
  logic          sram_CEN;
  logic          sram_GWEN;
  logic [DW-1:0] sram_WEN;
  logic [DW-1:0] sram_D;
  logic [DW-1:0] sram_Q;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_acc_cnt = 0;
  int pop_cyc[$];

  logic [DW-1:0] mac_mem [N];
  logic [DW-1:0] ref_mem [N];
  logic [DW-1:0] expq[$];

  logic          mon_pop;
  int            mon_occ;
  logic          mon_exp_rdy;
  logic [DW-1:0] mon_exp;
  logic [300:0]  pins_act;
  logic [300:0]  pins_exp;

  ct_f_spsram_2048x144_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ct_f_spsram_2048x144_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RSP_DEPTH (DEPTH),
    .INIT_EN   (1)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .init_done(init_done),
    .sram_A   (sram_A),
    .sram_CEN (sram_CEN),
    .sram_GWEN(sram_GWEN),
    .sram_WEN (sram_WEN),
    .sram_D   (sram_D),
    .sram_Q   (sram_Q)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  function automatic logic [DW-1:0] rand144();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Macro model: contents scrambled during reset so only the sweep can zero them.
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) mac_mem[i] <= rand144();
    end else if (!sram_CEN) begin
      if (!sram_GWEN) mac_mem[sram_A] <= (mac_mem[sram_A] & sram_WEN) | (sram_D & ~sram_WEN);
      else            sram_Q <= mac_mem[sram_A];
    end
  end

  // Reference model: word memory, in-order response queue and credit limit.
  always @(negedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) ref_mem[i] = '0;
      expq.delete();
    end else begin
      mon_pop = bus.rsp_vld && bus.rsp_rdy;
      mon_occ = expq.size() - (mon_pop ? 1 : 0);
      if (mon_pop) begin
        if (expq.size() == 0) begin
          checkOutput("rsp_unexpected", 320'(1), 320'(0));
        end else begin
          mon_exp = expq.pop_front();
          checkOutput("rsp_data", 320'(bus.rsp_rdata), 320'(mon_exp));
          pop_cyc.push_back(cyc);
        end
      end
      if (bus.req_vld) begin
        mon_exp_rdy = bus.req_wr || (mon_occ < DEPTH);
        checkOutput("req_rdy", 320'(bus.req_rdy), 320'(mon_exp_rdy));
        if (bus.req_rdy) begin
          pins_act = {sram_CEN, sram_GWEN, sram_A, sram_WEN, sram_D};
          if (!bus.req_wr) begin
            pins_exp = {1'b0, 1'b1, bus.req_addr, {DW{1'b1}}, {DW{1'b0}}};
            expq.push_back(ref_mem[bus.req_addr]);
            rd_acc_cnt++;
          end else if (bus.req_wmask == '0) begin
            pins_exp = {1'b1, 1'b1, {AW{1'b0}}, {DW{1'b1}}, {DW{1'b0}}};
          end else begin
            pins_exp = {1'b0, 1'b0, bus.req_addr, ~bus.req_wmask, bus.req_wdata};
            ref_mem[bus.req_addr] = (ref_mem[bus.req_addr] & ~bus.req_wmask) |
                                    (bus.req_wdata & bus.req_wmask);
          end
          checkOutput("sram_pins", 320'(pins_act), 320'(pins_exp));
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] m, input logic rr);
    @(posedge CLK);
    #1;
    bus.req_vld   = v;
    bus.req_wr    = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
    bus.rsp_rdy   = rr;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_req_rdy", 320'(bus.req_rdy), 320'(0));
    checkOutput("rst_rsp_vld", 320'(bus.rsp_vld), 320'(0));
    checkOutput("rst_rsp_rdata", 320'(bus.rsp_rdata), 320'(0));
    checkOutput("rst_init_done", 320'(init_done), 320'(0));
    checkOutput("rst_cen", 320'(sram_CEN), 320'(1));
    checkOutput("rst_gwen", 320'(sram_GWEN), 320'(1));
    checkOutput("rst_wen", 320'(sram_WEN), 320'({DW{1'b1}}));
    checkOutput("rst_a", 320'(sram_A), 320'(0));
    checkOutput("rst_d", 320'(sram_D), 320'(0));
  endtask

  task automatic waitInit();
    int n = 0;
    while (!init_done && n < N + 100) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("init_done", 320'(init_done), 320'(1));
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expq.size() != 0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("drain", 320'(expq.size()), 320'(0));
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    logic [DW-1:0] ones;
    logic [DW-1:0] pat;
    ones = '1;
    pat  = {18{8'hA5}};
    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wmask = '0; bus.rsp_rdy = 1'b1;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkResetValues();
    @(posedge CLK); #1 RST = 1'b0;

    // Full sweep: one zero write per cycle at ascending addresses.
    for (int i = 0; i < N; i++) begin
      @(negedge CLK);
      checkOutput("sweep", 320'({sram_CEN, sram_GWEN, |sram_WEN, |sram_D, init_done, sram_A}),
                  320'({5'b0, AW'(i)}));
    end
    @(negedge CLK);
    checkOutput("init_done_edge", 320'(init_done), 320'(1));

    $display("[TB] read after init with latency check");
    applyStimulus(1'b1, 1'b0, AW'(5), '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    @(negedge CLK);
    checkOutput("lat_n1", 320'(bus.rsp_vld), 320'(0));
    @(negedge CLK);
    checkOutput("lat_n2", 320'(bus.rsp_vld), 320'(1));
    waitDrain();

    $display("[TB] full write then read-after-write");
    applyStimulus(1'b1, 1'b1, AW'('h10), pat, ones, 1'b1);
    applyStimulus(1'b1, 1'b0, AW'('h10), '0, '0, 1'b1);
    idleCycles(1);
    waitDrain();

    $display("[TB] partial mask and zero mask writes");
    applyStimulus(1'b1, 1'b1, AW'('h10), ones, DW'(8'hFF), 1'b1);
    applyStimulus(1'b1, 1'b0, AW'('h10), '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b1, AW'('h10), rand144(), '0, 1'b1);
    @(negedge CLK);
    checkOutput("zmask_cen", 320'(sram_CEN), 320'(1));
    applyStimulus(1'b1, 1'b0, AW'('h10), '0, '0, 1'b1);
    idleCycles(1);
    waitDrain();

    $display("[TB] backpressure with rsp_rdy low");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, AW'('h20 + i), rand144(), ones, 1'b1);
    start = rd_acc_cnt;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, AW'('h20 + i), '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b1, AW'('h30), rand144(), ones, 1'b0);
    @(negedge CLK);
    checkOutput("wr_while_full", 320'(bus.req_rdy), 320'(1));
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge CLK);
    checkOutput("reads_accepted", 320'(rd_acc_cnt - start), 320'(DEPTH));
    checkOutput("held_rsp_vld", 320'(bus.rsp_vld), 320'(1));
    idleCycles(2);
    waitDrain();

    $display("[TB] back-to-back reads");
    pop_cyc.delete();
    start = rd_acc_cnt;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, AW'($urandom_range(0, 63)), '0, '0, 1'b1);
    idleCycles(1);
    waitDrain();
    checkOutput("b2b_accepted", 320'(rd_acc_cnt - start), 320'(16));
    checkOutput("b2b_count", 320'(pop_cyc.size()), 320'(16));
    for (int i = 1; i < pop_cyc.size(); i++)
      checkOutput("b2b_gap", 320'(pop_cyc[i] - pop_cyc[i-1]), 320'(1));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      int sel;
      logic [DW-1:0] m;
      sel = $urandom_range(0, 3);
      m = (sel == 0) ? '0 : (sel == 1) ? ones : rand144();
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 31)), rand144(), m, $urandom_range(0, 3) != 0);
    end
    idleCycles(1);
    waitDrain();

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b1, 1'b0, AW'('h10), '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, AW'('h11), '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    checkResetValues();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      checkOutput("restart_sweep", 320'({bus.rsp_vld, sram_CEN, sram_A}), 320'({2'b00, AW'(i)}));
    end
    waitInit();

    $display("[TB] reset in the middle of the sweep");
    @(posedge CLK); #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (1000) @(negedge CLK);
    @(negedge CLK);
    checkOutput("sweep_1000", 320'({sram_CEN, sram_A}), 320'({1'b0, AW'(1000)}));
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    checkResetValues();
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    checkOutput("sweep_restart0", 320'({sram_CEN, sram_GWEN, sram_A}), 320'(0));
    waitInit();
    applyStimulus(1'b1, 1'b0, AW'(5), '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, AW'('h10), '0, '0, 1'b1);
    idleCycles(1);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ct_f_spsram_2048x144_ctrl.md
# ct_f_spsram_2048x144_ctrl

Request-side controller sitting directly upstream of the 2048x144 single-port SRAM macro. It turns a valid/ready request stream of reads and masked writes into the macro's active-low CEN/GWEN/WEN/A/D pins, and returns read data through a small response FIFO with credit-based backpressure. After reset it zero-initialises the whole array before accepting traffic.

## Interface
Parameters:
- ADDR_WIDTH, 11, SRAM address width (2^ADDR_WIDTH entries)
- DATA_WIDTH, 144, word width
- RSP_DEPTH, 2, response FIFO entries (>=2)
- INIT_EN, 1, 1 = zero-fill sweep after reset; 0 = start in RUN

Ports (one clock; reset asynchronous, active-high):
- CLK  in  1  clock; also drives the SRAM macro
- RST  in  1  async active-high reset
- req_vld  in  1  request valid
- req_rdy  out  1  request accepted when req_vld & req_rdy
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_wmask  in  DATA_WIDTH  active-high bit write mask
- rsp_vld  out  1  read data valid
- rsp_rdy  in  1  consumer ready
- rsp_rdata  out  DATA_WIDTH  read data, in request order
- init_done  out  1  high once state is RUN
- sram_A  out  ADDR_WIDTH  to macro A
- sram_CEN  out  1  to macro CEN, active low
- sram_GWEN  out  1  to macro GWEN, active low
- sram_WEN  out  DATA_WIDTH  to macro WEN, active low per bit
- sram_D  out  DATA_WIDTH  to macro D
- sram_Q  in  DATA_WIDTH  from macro Q, valid cycle after read access

## Operation
- States: INIT, RUN. Reset -> INIT if INIT_EN else RUN.
- INIT: counter 0..2^ADDR_WIDTH-1; each cycle CEN=0, GWEN=0, WEN=all 0, D=0, A=counter. After last address -> RUN. req_rdy=0 throughout.
- RUN, accepted read: CEN=0, GWEN=1, A=req_addr same cycle (combinational from accepted request); rd_pend set for next cycle; sram_Q pushed into FIFO at that cycle's end.
- RUN, accepted write: CEN=0, GWEN=0, WEN=~req_wmask, D=req_wdata, A=req_addr. No response. wmask all-zero: accepted, CEN=1 (no access).
- No access: CEN=1, GWEN=1, WEN=all 1, D=0, A=0.
- Credit: occ = fifo_count + rd_pend - (rsp_vld & rsp_rdy). req_rdy = RUN & (req_wr | occ < RSP_DEPTH). Writes never blocked by FIFO.
- FIFO: rsp_vld = count != 0; rsp_rdata = head entry, stable while rsp_vld & !rsp_rdy. Push and pop same cycle allowed; overflow impossible by credit rule (assert).
- Order: single port serialises, so read after write to same address returns new data.

## Timing
- Reset values: req_rdy=0, rsp_vld=0, rsp_rdata=0, init_done=INIT_EN?0:1, sram_CEN=1, sram_GWEN=1, sram_WEN=all 1, sram_A=0, sram_D=0 (INIT drives sweep from first cycle after reset release).
- Init sweep: exactly 2^ADDR_WIDTH cycles; init_done rises the cycle after last sweep write.
- Read latency: accepted cycle N -> macro access N -> sram_Q valid N+1 -> rsp_vld at N+2.
- Throughput: one request/cycle with rsp_rdy=1 and RSP_DEPTH>=2.
- Reset mid-operation: FIFO, rd_pend, counter cleared; in-flight reads dropped; sweep restarts from 0.

## Structure
- Package ct_f_spsram_ctrl_pkg: state enum (INIT, RUN), idle pin constants (CEN/GWEN inactive, WEN all-ones).
- Sub-module ct_f_spsram_rsp_fifo: parameterised sync FIFO (DATA_WIDTH x RSP_DEPTH), push/pop/count, async active-high reset.

## Test plan
- Reset, INIT_EN=1 -> 2048 cycles of CEN=0/GWEN=0 with A 0..2047, then init_done=1; read addr 5 -> rsp_rdata=0.
- Write addr 0x10 data 0xA5.., mask all-ones; read 0x10 next cycle -> rsp_vld at N+2, data 0xA5...
- Write 0x10 data all-ones mask 0x00FF; read -> low 8 bits 1, rest prior value; all-zero mask write -> CEN stays 1.
- rsp_rdy=0, issue 4 reads -> exactly RSP_DEPTH accepted, req_rdy=0 after; writes still accepted; release rsp_rdy -> responses in order.
- 16 back-to-back reads, rsp_rdy=1 -> req_rdy stays 1, 16 responses on consecutive cycles.
- Assert RST at sweep address 1000 and with 2 reads in flight -> outputs return to reset values, no stale rsp_vld, sweep restarts at 0.
